// File: rtl/disp_pdm_rx.sv
// disp_pdm_rx -- pulse-density stream decoder with slew-limited brightness output.
//
// Counts the ones in a 1-bit pulse-density stream over windows of 256 sample
// ticks. The result is an 8-bit density level. Each completed window updates the
// raw measurement. It also moves the display brightness word toward the
// measurement, with the level floored at min_level.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   tsc_1ppus   one-clk strobe, once per microsecond
//   enable      decoder run enable (level)
//   pdm_in      asynchronous pulse-density input
//   min_level   floor applied to the decoded level, sampled at window end
//   disp_pdm    slewed brightness word to the display dimmer
//   meas        raw decoded density of the last completed window
//   meas_valid  one-clk pulse when meas and disp_pdm update
module disp_pdm_rx #(
  parameter int DIV         = 2,
  parameter int SLEW_STEP   = 1,
  parameter int RESET_LEVEL = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tsc_1ppus,
  input  logic       enable,
  input  logic       pdm_in,
  input  logic [7:0] min_level,
  output logic [7:0] disp_pdm,
  output logic [7:0] meas,
  output logic       meas_valid
);

  typedef enum logic [1:0] {IDLE, FILL, TRACK} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
  localparam logic [8:0] STEP9     = 9'(SLEW_STEP);
  localparam logic [7:0] RST_LEVEL = 8'(RESET_LEVEL);

  state_t     state_q, state_d;
  logic [1:0] sync_q;
  logic [7:0] div_q, div_d;
  logic [7:0] samp_q, samp_d;
  logic [8:0] ones_q, ones_d;
  logic [7:0] disp_q, disp_d;
  logic [7:0] meas_q, meas_d;
  logic       valid_q, valid_d;

  logic       pdm_s;
  logic       tick;
  logic       last_tick;
  logic [8:0] cnt;
  logic [7:0] level;
  logic [7:0] target;
  logic [8:0] t9, d9;
  logic [7:0] slewed;

  assign pdm_s     = sync_q[1];
  // enable gates the tick, so a strobe coinciding with enable falling is dropped
  assign tick      = enable && tsc_1ppus && (div_q == DIV_LAST);
  assign last_tick = tick && (samp_q == 8'd255);

  // Window count includes the closing tick's sample; 256 saturates to 255
  assign cnt    = ones_q + {8'd0, pdm_s};
  assign level  = cnt[8] ? 8'hFF : cnt[7:0];
  assign target = (level > min_level) ? level : min_level;

  // Slew limiter in 9 bits so disp +/- step never wraps
  assign t9 = {1'b0, target};
  assign d9 = {1'b0, disp_q};

  always_comb begin
    slewed = target;
    if (t9 >= d9) begin
      if ((t9 - d9) > STEP9) slewed = 8'(d9 + STEP9);
    end else begin
      if ((d9 - t9) > STEP9) slewed = 8'(d9 - STEP9);
    end
  end

  // Sample-tick divider and window accumulators
  always_comb begin
    div_d  = div_q;
    samp_d = samp_q;
    ones_d = ones_q;
    if (!enable) begin
      div_d  = 8'd0;
      samp_d = 8'd0;
      ones_d = 9'd0;
    end else if (tsc_1ppus) begin
      if (div_q == DIV_LAST) begin
        div_d  = 8'd0;
        samp_d = samp_q + 8'd1;
        ones_d = last_tick ? 9'd0 : cnt;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  // Mode control and output update
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    meas_d  = meas_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FILL;
      end
      FILL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (last_tick) begin
          meas_d  = level;
          valid_d = 1'b1;
          disp_d  = target;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (last_tick) begin
          meas_d  = level;
          valid_d = 1'b1;
          disp_d  = slewed;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b00;
      div_q   <= 8'd0;
      samp_q  <= 8'd0;
      ones_q  <= 9'd0;
      disp_q  <= RST_LEVEL;
      meas_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], pdm_in};
      div_q   <= div_d;
      samp_q  <= samp_d;
      ones_q  <= ones_d;
      disp_q  <= disp_d;
      meas_q  <= meas_d;
      valid_q <= valid_d;
    end
  end

  assign disp_pdm   = disp_q;
  assign meas       = meas_q;
  assign meas_valid = valid_q;

endmodule

// File: tb/tb_disp_pdm_rx.sv
module tb_disp_pdm_rx;

  localparam int DIV     = 2;
  localparam int STEP    = 30;
  localparam int RST_LVL = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       tsc_1ppus;
  logic       enable;
  logic       pdm_in;
  logic [7:0] min_level;
  logic [7:0] disp_pdm;
  logic [7:0] meas;
  logic       meas_valid;

  disp_pdm_rx #(.DIV(DIV), .SLEW_STEP(STEP), .RESET_LEVEL(RST_LVL)) dut (
    .clk        (clk),
    .rst        (rst),
    .tsc_1ppus  (tsc_1ppus),
    .enable     (enable),
    .pdm_in     (pdm_in),
    .min_level  (min_level),
    .disp_pdm   (disp_pdm),
    .meas       (meas),
    .meas_valid (meas_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: expected meas and disp_pdm for each completed window
  typedef struct {
    int m;
    int d;
  } exp_t;
  exp_t exp_q[$];

  // Stimulus knobs
  int density = 0;   // probability (of 256) that pdm_in is 1 on a given clk
  int tsc_pct = 88;  // probability (percent) of a strobe on a given clk
  bit mon_on  = 1'b0;

  // Behavioural reference: integer counts of strobes, samples and ones
  int m_strobes, m_samples, m_ones, m_disp, m_meas, windows;
  bit m_fill, m_valid, s1, s2, ps;
  int lvl, tgt, diff;

  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      m_strobes = 0; m_samples = 0; m_ones = 0;
      m_disp = RST_LVL; m_meas = 0; m_fill = 1'b1;
      s1 = 1'b0; s2 = 1'b0;
    end else begin
      ps = s2;  // value seen after the two-stage synchronizer
      s2 = s1;
      s1 = pdm_in;
      if (!enable) begin
        m_strobes = 0; m_samples = 0; m_ones = 0; m_fill = 1'b1;
      end else if (tsc_1ppus) begin
        m_strobes++;
        if (m_strobes == DIV) begin
          m_strobes = 0;
          m_ones += int'(ps);
          m_samples++;
          if (m_samples == 256) begin
            lvl = (m_ones > 255) ? 255 : m_ones;
            tgt = (lvl > int'(min_level)) ? lvl : int'(min_level);
            if (m_fill) begin
              m_disp = tgt;
            end else begin
              diff = tgt - m_disp;
              if (diff > STEP)       m_disp += STEP;
              else if (diff < -STEP) m_disp -= STEP;
              else                   m_disp = tgt;
            end
            m_meas = lvl;
            m_valid = 1'b1;
            exp_q.push_back('{m: lvl, d: m_disp});
            windows++;
            m_fill = 1'b0;
            m_samples = 0;
            m_ones = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every cycle, pops the scoreboard on each meas_valid pulse
  always @(negedge clk) begin
    if (mon_on) begin
      chk("meas_valid", {8'd0, meas_valid}, {8'd0, m_valid});
      chk("disp_hold", {1'b0, disp_pdm}, 9'(m_disp));
      chk("meas_hold", {1'b0, meas}, 9'(m_meas));
      if (meas_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got meas=%0d disp=%0d expected no window at %0t",
                   meas, disp_pdm, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("window_meas", {1'b0, meas}, 9'(e.m));
          chk("window_disp", {1'b0, disp_pdm}, 9'(e.d));
          $display("window: meas=%0d disp_pdm=%0d (expected %0d/%0d) min_level=%0d",
                   meas, disp_pdm, e.m, e.d, min_level);
        end
      end
    end
  end

  // Random strobe and density-controlled input drive
  always @(negedge clk) begin
    tsc_1ppus = ($urandom_range(0, 99) < tsc_pct);
    pdm_in    = ($urandom_range(0, 255) < density);
  end

  task automatic wait_windows(input int n);
    int target_w = windows + n;
    int cyc = 0;
    while (windows < target_w && cyc < 2000 * n) begin
      @(negedge clk);
      cyc++;
    end
    if (windows < target_w) begin
      checks++;
      errors++;
      $display("FAIL window_timeout: got %0d windows expected %0d", windows, target_w);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; min_level = 8'd0;
    tsc_1ppus = 1'b0; pdm_in = 1'b0;
    windows = 0;
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);      // idle: reset values, no meas_valid

    // Fill window with all ones -> 255 directly
    density = 256; enable = 1'b1;
    wait_windows(1);

    // Slew down toward 0
    density = 0;
    wait_windows(3);

    // Random densities, min_level changed mid-window
    for (int i = 0; i < 6; i++) begin
      density = $urandom_range(0, 256);
      min_level = 8'($urandom_range(0, 255));
      repeat ($urandom_range(10, 300)) @(negedge clk);
      min_level = 8'($urandom_range(0, 200));
      wait_windows(1);
    end

    density = 128; min_level = 8'd0;
    wait_windows(2);

    // Abort mid-window, then re-enable: new fill with floor 16
    repeat (300) @(negedge clk);
    enable = 1'b0;
    repeat (50) @(negedge clk);
    enable = 1'b1; density = 0; min_level = 8'd16;
    wait_windows(1);

    // Reset in tracking mode, next window must be a fill
    density = 210; min_level = 8'd0;
    wait_windows(1);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_windows(2);

    // Short enable glitches at random points
    for (int i = 0; i < 4; i++) begin
      density = $urandom_range(0, 256);
      repeat ($urandom_range(50, 600)) @(negedge clk);
      enable = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      enable = 1'b1;
    end
    wait_windows(2);

    repeat (5) @(negedge clk);
    chk("queue_empty", 9'(exp_q.size()), 9'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
